// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux
//
// Address decoder and response multiplexor for the AHB-Lite subsystem.
// The address side turns the top nibble of HADDR into one-hot subordinate
// selects, and sends unmapped regions to the default subordinate. The data
// side registers the data-phase selection and steers that subordinate's
// HRDATA/HRESP/HREADYOUT back to the manager. A stall watchdog abandons a
// data phase that has waited too long and answers it with a two-cycle ERROR.
// A saturating counter records every completed ERROR response.
//
// Ports
//   HCLK         clock, all state on the rising edge
//   HRESETn      asynchronous active-low reset
//   HADDR        manager address
//   HSEL_S       one-hot select to the mapped subordinates
//   HSEL_D       select to the default subordinate
//   HRDATA_S     subordinate read data, sub i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HRESP_S      subordinate responses, sub i at [2*i +: 2]
//   HREADYOUT_S  subordinate ready
//   HRDATA_D     default subordinate read data
//   HRESP_D      default subordinate response
//   HREADYOUT_D  default subordinate ready
//   HRDATA       read data to the manager
//   HRESP        response to the manager (00 OKAY, 01 ERROR)
//   HREADY       ready to the manager, also every subordinate's HREADYin
//   ERR_COUNT    saturating count of completed ERROR responses

module ahb_decoder_mux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SUBS   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  output logic [NUM_SUBS-1:0]            HSEL_S,
  output logic                           HSEL_D,
  input  logic [NUM_SUBS*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SUBS*2-1:0]          HRESP_S,
  input  logic [NUM_SUBS-1:0]            HREADYOUT_S,
  input  logic [DATA_WIDTH-1:0]          HRDATA_D,
  input  logic [1:0]                     HRESP_D,
  input  logic                           HREADYOUT_D,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [1:0]                     HRESP,
  output logic                           HREADY,
  output logic [7:0]                     ERR_COUNT
);

  // The counter must be able to hold TIMEOUT itself; with the watchdog
  // disabled a single bit keeps the declarations legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  // One select bit per mapped subordinate plus the default at the top;
  // all-zero means no data phase is outstanding.
  localparam int SEL_W = NUM_SUBS + 1;

  typedef enum logic [1:0] {
    NORMAL,
    TO_ERR1,
    TO_ERR2
  } state_t;

  state_t                 state;
  logic [SEL_W-1:0]       dsel;
  logic [SEL_W-1:0]       decode_sel;
  logic [CNT_W-1:0]       stall_cnt;
  logic [7:0]             err_count;
  logic [3:0]             region;
  logic [DATA_WIDTH-1:0]  mux_rdata;
  logic [1:0]             mux_resp;
  logic                   mux_ready;
  logic                   stalled;
  logic                   timeout_hit;
  logic                   unused_addr_bits;

  assign region = HADDR[ADDR_WIDTH-1 -: 4];

  // Only the region nibble takes part in decode.
  assign unused_addr_bits = ^HADDR[ADDR_WIDTH-5:0];

  // Exactly one select is high for every address, reset or not.
  always_comb begin
    decode_sel = '0;
    for (int i = 0; i < NUM_SUBS; i++) begin
      decode_sel[i] = (region == 4'(i));
    end
    decode_sel[NUM_SUBS] = ({1'b0, region} >= 5'(NUM_SUBS));
  end

  assign HSEL_S = decode_sel[NUM_SUBS-1:0];
  assign HSEL_D = decode_sel[NUM_SUBS];

  // dsel is one-hot or zero, so an AND-OR style mux needs no priority.
  // With nothing outstanding the bus looks idle and ready.
  always_comb begin
    mux_rdata = '0;
    mux_resp  = 2'b00;
    mux_ready = 1'b1;
    for (int i = 0; i < NUM_SUBS; i++) begin
      if (dsel[i]) begin
        mux_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_resp  = HRESP_S[2*i +: 2];
        mux_ready = HREADYOUT_S[i];
      end
    end
    if (dsel[NUM_SUBS]) begin
      mux_rdata = HRDATA_D;
      mux_resp  = HRESP_D;
      mux_ready = HREADYOUT_D;
    end
  end

  assign stalled     = (dsel != '0) && !mux_ready;
  // Fires on the TIMEOUT-th consecutive stalled cycle; a subordinate that
  // raises HREADYOUT in that same cycle is not stalled and so wins.
  assign timeout_hit = (TIMEOUT != 0) && stalled && (stall_cnt == STALL_LIMIT);

  // While the watchdog is answering, the abandoned subordinate is ignored.
  always_comb begin
    HRDATA = mux_rdata;
    HRESP  = mux_resp;
    HREADY = mux_ready;
    case (state)
      TO_ERR1: begin
        HRDATA = '0;
        HRESP  = 2'b01;
        HREADY = 1'b0;
      end
      TO_ERR2: begin
        HRDATA = '0;
        HRESP  = 2'b01;
        HREADY = 1'b1;
      end
      default: ;
    endcase
  end

  // The final ERROR cycle has HREADY high, so dsel picks up the next
  // address phase there without any extra handling.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= NORMAL;
      dsel      <= '0;
      stall_cnt <= '0;
      err_count <= '0;
    end else begin
      if (HREADY) begin
        dsel <= decode_sel;
      end
      if (HREADY && (HRESP == 2'b01) && (err_count != 8'hFF)) begin
        err_count <= err_count + 1'b1;
      end
      case (state)
        NORMAL: begin
          if (timeout_hit) begin
            state <= TO_ERR1;
          end
          stall_cnt <= stalled ? stall_cnt + 1'b1 : '0;
        end
        TO_ERR1: begin
          state     <= TO_ERR2;
          stall_cnt <= '0;
        end
        default: begin
          state     <= NORMAL;
          stall_cnt <= '0;
        end
      endcase
    end
  end

  assign ERR_COUNT = err_count;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// tb_ahb_decoder_mux
//
// Self-checking bench for ahb_decoder_mux. Inputs change just after the
// falling edge and outputs are sampled 1 time unit later. A behavioural
// model tracks which subordinate owns the data phase, how long it has been
// waiting, the watchdog answer and the error tally.

module tb_ahb_decoder_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [AW-1:0]    HADDR;
  logic [NS-1:0]    HSEL_S;
  logic             HSEL_D;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS*2-1:0]  HRESP_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [DW-1:0]    HRDATA_D;
  logic [1:0]       HRESP_D;
  logic             HREADYOUT_D;
  logic [DW-1:0]    HRDATA;
  logic [1:0]       HRESP;
  logic             HREADY;
  logic [7:0]       ERR_COUNT;

  // Subordinate behaviour; slot NS is the default subordinate.
  logic [DW-1:0] slot_data  [NS+1];
  logic [1:0]    slot_resp  [NS+1];
  logic          slot_ready [NS+1];

  int total = 0;
  int bad   = 0;

  // Model state: owner of the data phase (-1 none, NS default), watchdog
  // phase (0 idle, 1 first ERROR cycle, 2 second), stall run length, errors.
  int m_tgt;
  int m_wd;
  int m_stall;
  int m_errs;

  logic          exp_ready;
  logic [1:0]    exp_resp;
  logic [DW-1:0] exp_data;

  ahb_decoder_mux #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_SUBS(NS),
    .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .HADDR(HADDR),
    .HSEL_S(HSEL_S),
    .HSEL_D(HSEL_D),
    .HRDATA_S(HRDATA_S),
    .HRESP_S(HRESP_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRDATA_D(HRDATA_D),
    .HRESP_D(HRESP_D),
    .HREADYOUT_D(HREADYOUT_D),
    .HRDATA(HRDATA),
    .HRESP(HRESP),
    .HREADY(HREADY),
    .ERR_COUNT(ERR_COUNT)
  );

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      HRDATA_S[i*DW +: DW] = slot_data[i];
      HRESP_S[2*i +: 2]    = slot_resp[i];
      HREADYOUT_S[i]       = slot_ready[i];
    end
    HRDATA_D    = slot_data[NS];
    HRESP_D     = slot_resp[NS];
    HREADYOUT_D = slot_ready[NS];
  end

  function automatic int regionOf(input logic [AW-1:0] a);
    int r;
    r = int'(a[AW-1 -: 4]);
    return (r < NS) ? r : NS;
  endfunction

  task automatic modelReset();
    m_tgt   = -1;
    m_wd    = 0;
    m_stall = 0;
    m_errs  = 0;
  endtask

  task automatic modelOutputs();
    if (m_wd == 1) begin
      exp_ready = 1'b0; exp_resp = 2'b01; exp_data = '0;
    end else if (m_wd == 2) begin
      exp_ready = 1'b1; exp_resp = 2'b01; exp_data = '0;
    end else if (m_tgt < 0) begin
      exp_ready = 1'b1; exp_resp = 2'b00; exp_data = '0;
    end else begin
      exp_ready = slot_ready[m_tgt];
      exp_resp  = slot_resp[m_tgt];
      exp_data  = slot_data[m_tgt];
    end
  endtask

  // Advance the model across one rising edge.
  task automatic modelEdge();
    modelOutputs();
    if (exp_ready && exp_resp == 2'b01) begin
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
    end
    if (m_wd == 1) begin
      m_wd = 2;
    end else if (m_wd == 2) begin
      m_wd = 0;
    end else if (m_tgt >= 0 && !slot_ready[m_tgt]) begin
      m_stall = m_stall + 1;
      if (TO != 0 && m_stall == TO) begin
        m_wd    = 1;
        m_stall = 0;
      end
    end else begin
      m_stall = 0;
    end
    if (exp_ready) begin
      m_tgt = regionOf(HADDR);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int r;
    logic [NS-1:0] exp_sel;
    modelOutputs();
    r = regionOf(HADDR);
    exp_sel = '0;
    if (r < NS) exp_sel[r] = 1'b1;
    checkOutput("hsel_s", 32'(HSEL_S), 32'(exp_sel));
    checkOutput("hsel_d", 32'(HSEL_D), 32'(r == NS));
    checkOutput("hrdata", HRDATA, exp_data);
    checkOutput("hresp", 32'(HRESP), 32'(exp_resp));
    checkOutput("hready", 32'(HREADY), 32'(exp_ready));
    checkOutput("err_count", 32'(ERR_COUNT), 32'(m_errs));
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input int idx, input logic rdy,
                               input logic [1:0] rsp, input logic [DW-1:0] data);
    HADDR           = addr;
    slot_ready[idx] = rdy;
    slot_resp[idx]  = rsp;
    slot_data[idx]  = data;
  endtask

  task automatic settle();
    #1;
    checkAll();
  endtask

  task automatic advance();
    @(posedge HCLK);
    modelEdge();
    @(negedge HCLK);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic quietSlots();
    for (int i = 0; i <= NS; i++) begin
      slot_ready[i] = 1'b1;
      slot_resp[i]  = 2'b00;
      slot_data[i]  = 32'hC0DE_0000 + 32'(i);
    end
  endtask

  initial begin
    int n;
    HRESETn = 1'b1;
    HADDR   = 32'h2000_0000;
    quietSlots();
    modelReset();
    #1 HRESETn = 1'b0;

    // Reset state
    @(negedge HCLK);
    settle();
    checkOutput("rst_hsel_s", 32'(HSEL_S), 32'h4);
    checkOutput("rst_hready", 32'(HREADY), 32'h1);
    checkOutput("rst_hresp", 32'(HRESP), 32'h0);
    checkOutput("rst_hrdata", HRDATA, 32'h0);
    checkOutput("rst_err", 32'(ERR_COUNT), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cycle();

    // Back-to-back zero-wait reads from sub1 then sub3
    applyStimulus(32'h1000_0000, 1, 1'b1, 2'b00, 32'hA5A5_0001);
    cycle();
    applyStimulus(32'h3000_0000, 3, 1'b1, 2'b00, 32'h5A5A_0003);
    settle();
    checkOutput("b2b_sub1", HRDATA, 32'hA5A5_0001);
    advance();
    HADDR = 32'h2000_0000;
    settle();
    checkOutput("b2b_sub3", HRDATA, 32'h5A5A_0003);
    advance();

    // Default subordinate two-cycle ERROR
    HADDR = 32'hF000_0000;
    settle();
    checkOutput("dflt_hsel_d", 32'(HSEL_D), 32'h1);
    advance();
    applyStimulus(32'h2000_0000, NS, 1'b0, 2'b01, 32'h0);
    settle();
    checkOutput("derr1_resp", 32'(HRESP), 32'h1);
    checkOutput("derr1_ready", 32'(HREADY), 32'h0);
    advance();
    applyStimulus(32'h2000_0000, NS, 1'b1, 2'b01, 32'h0);
    settle();
    checkOutput("derr2_resp", 32'(HRESP), 32'h1);
    checkOutput("derr2_ready", 32'(HREADY), 32'h1);
    advance();
    quietSlots();
    settle();
    checkOutput("derr_count", 32'(ERR_COUNT), 32'h1);
    advance();

    // Watchdog abort after TO stalled cycles
    applyStimulus(32'h0000_0000, 0, 1'b1, 2'b00, 32'h0);
    cycle();
    applyStimulus(32'h1000_0000, 0, 1'b0, 2'b00, 32'h0);
    slot_data[1] = 32'h1111_0001;
    for (int i = 0; i < TO; i++) begin
      settle();
      checkOutput("to_stall_ready", 32'(HREADY), 32'h0);
      advance();
    end
    settle();
    checkOutput("to_err1_resp", 32'(HRESP), 32'h1);
    checkOutput("to_err1_ready", 32'(HREADY), 32'h0);
    advance();
    settle();
    checkOutput("to_err2_resp", 32'(HRESP), 32'h1);
    checkOutput("to_err2_ready", 32'(HREADY), 32'h1);
    advance();
    HADDR = 32'h2000_0000;
    settle();
    checkOutput("to_next_data", HRDATA, 32'h1111_0001);
    checkOutput("to_next_resp", 32'(HRESP), 32'h0);
    checkOutput("to_err_count", 32'(ERR_COUNT), 32'h2);
    advance();
    quietSlots();

    // Stall of TO-1 cycles, released on the TO-th: no abort
    applyStimulus(32'h0000_0000, 0, 1'b1, 2'b00, 32'h0);
    cycle();
    applyStimulus(32'h2000_0000, 0, 1'b0, 2'b00, 32'h0);
    for (int i = 0; i < TO - 1; i++) cycle();
    applyStimulus(32'h2000_0000, 0, 1'b1, 2'b00, 32'h0000_00AA);
    settle();
    checkOutput("st15_ready", 32'(HREADY), 32'h1);
    checkOutput("st15_resp", 32'(HRESP), 32'h0);
    checkOutput("st15_data", HRDATA, 32'h0000_00AA);
    checkOutput("st15_err", 32'(ERR_COUNT), 32'h2);
    advance();
    quietSlots();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(32'hF000_0000, NS, 1'b0, 2'b01, 32'h0);
      cycle();
      applyStimulus(32'hF000_0000, NS, 1'b1, 2'b01, 32'h0);
      cycle();
    end
    settle();
    checkOutput("sat_err", 32'(ERR_COUNT), 32'd255);
    advance();
    quietSlots();

    // Reset to clear the counter, then random traffic
    HRESETn = 1'b0;
    modelReset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1000; c++) begin
        HADDR = $urandom;
        for (int s = 0; s <= NS; s++) begin
          slot_ready[s] = (phase == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
          slot_resp[s]  = ($urandom_range(7) == 0) ? 2'b01 : 2'b00;
          slot_data[s]  = $urandom;
        end
        cycle();
      end
    end

    // Reset asserted while the watchdog is in its first ERROR cycle
    quietSlots();
    HADDR = 32'h0000_0000;
    for (int i = 0; i < 3; i++) cycle();
    slot_ready[0] = 1'b0;
    n = 0;
    while (m_wd != 1 && n < 40) begin
      cycle();
      n++;
    end
    total++;
    assert (n < 40) else begin
      bad++;
      $error("[TB] FAIL reach_err1 observed=%0d expected=<40 cycles", n);
    end
    settle();
    checkOutput("pre_rst_ready", 32'(HREADY), 32'h0);
    checkOutput("pre_rst_resp", 32'(HRESP), 32'h1);
    #2 HRESETn = 1'b0;
    modelReset();
    #1;
    checkOutput("arst_ready", 32'(HREADY), 32'h1);
    checkOutput("arst_resp", 32'(HRESP), 32'h0);
    checkOutput("arst_err", 32'(ERR_COUNT), 32'h0);
    checkAll();
    @(negedge HCLK);
    HRESETn = 1'b1;
    slot_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
